// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the I/D-cache memory arbiter:
//               FSM state encoding, requester ids and bank-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    // Requester ids
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // The bank index is a 2-bit field of the word address
    localparam int BANK_W = 2;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arb_rdpipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_rdpipe
// Description : RD_LAT-deep shift register tracking outstanding memory reads.
//               Each stage carries {valid, requester id}. The last stage marks
//               the read whose data is on mem_rdata this cycle; head_id names
//               the oldest read still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_rdpipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    output logic ret_valid,
    output logic ret_id,
    output logic head_id,
    output logic empty
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] id_q;
    logic [RD_LAT-1:0] id_d;

    generate
        if (RD_LAT == 1) begin : g_lat1
            // Single stage: the new read lands directly in the return slot
            always_comb begin
                valid_d = push;
                id_d    = push_id;
            end
        end else begin : g_latn
            // Shift toward the return slot, inserting the new read at stage 0
            always_comb begin
                valid_d = {valid_q[RD_LAT-2:0], push};
                id_d    = {id_q[RD_LAT-2:0], push_id};
            end
        end
    endgenerate

    // Pipe register; reset discards every in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    // Oldest valid stage wins: higher index means issued earlier
    always_comb begin
        head_id = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (valid_q[k]) head_id = id_q[k];
        end
    end

    assign ret_valid = valid_q[RD_LAT-1];
    assign ret_id    = id_q[RD_LAT-1];
    assign empty     = ~|valid_q;

endmodule : mem_arb_rdpipe
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Grants the four-banked main memory to the I-cache (req 0) or
//               the D-cache (req 1) for a whole line transaction, forwards the
//               owner's word accesses, stalls on busy banks and routes read
//               data back to the issuing requester.
//               Build option MEM_ARB_DCACHE_PRIORITY_EN: when defined, the
//               D-cache always wins a tie; otherwise ties are round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RD_LAT   = 2,
    parameter int BANK_LSB = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [1:0]          rd,
    input  logic [1:0]          wr,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          stall,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          err,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_rd,
    output logic                mem_wr,
    input  logic [3:0]          mem_busy,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_err
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic                own_active;
    logic                own_id;
    logic                own_rd;
    logic                own_wr;
    logic                own_release;
    logic [ADDR_W-1:0]   own_addr;
    logic [BANK_W-1:0]   own_bank;
    logic                tie_pick;
    logic [1:0]          err_strobe;
    logic                ret_valid;
    logic                ret_id;
    logic                head_id;
    logic                pipe_empty;

    // Owner selection follows the state; memory outputs are a straight mux
    always_comb begin
        own_active = (state_q == OWN0) || (state_q == OWN1);
        own_id     = (state_q == OWN1);
        own_addr   = own_id ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        mem_wdata  = own_id ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
        own_rd     = rd[own_id];
        own_wr     = wr[own_id];
    end

    assign own_bank = own_addr[BANK_LSB +: BANK_W];
    assign mem_addr = own_addr;

`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    assign tie_pick = REQ_D;
`else
    logic last_owner_q;
    logic last_owner_d;

    assign last_owner_d = own_release ? own_id : last_owner_q;
    assign tie_pick     = ~last_owner_q;

    // Remember who released last; reset favours requester 0 on the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_owner_q <= REQ_D;
        else     last_owner_q <= last_owner_d;
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state, grant, stall and issue decode
    always_comb begin
        state_d     = state_q;
        gnt         = 2'b00;
        stall       = 2'b11;
        err_strobe  = 2'b00;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        own_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (req == 2'b11)  state_d = tie_pick ? OWN1 : OWN0;
                else if (req[0])   state_d = OWN0;
                else if (req[1])   state_d = OWN1;
            end
            OWN0, OWN1: begin
                gnt[own_id] = 1'b1;
                if (!req[own_id]) begin
                    // Release cycle: any strobe riding along is ignored
                    own_release = 1'b1;
                    state_d     = DRAIN;
                end else if (own_rd && own_wr) begin
                    stall[own_id]      = 1'b0;
                    err_strobe[own_id] = 1'b1;
                end else if (own_rd || own_wr) begin
                    if (!mem_busy[own_bank]) begin
                        stall[own_id] = 1'b0;
                        mem_rd        = own_rd;
                        mem_wr        = own_wr;
                    end
                end else begin
                    stall[own_id] = 1'b0;
                end
            end
            DRAIN: begin
                if (pipe_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Error routing: memory errors go to the oldest in-flight reader first
    always_comb begin
        err = err_strobe;
        if (mem_err) begin
            if (!pipe_empty)     err[head_id] = 1'b1;
            else if (own_active) err[own_id]  = 1'b1;
        end
    end

    mem_arb_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_rd),
        .push_id   (own_id),
        .ret_valid (ret_valid),
        .ret_id    (ret_id),
        .head_id   (head_id),
        .empty     (pipe_empty)
    );

    assign rvalid = ret_valid ? (ret_id ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = mem_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios plus
//               randomized traffic, compared each cycle against a
//               transaction-level reference model (owner / draining flags and
//               a queue of in-flight reads with due cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int RD_LAT   = 2;
    localparam int BANK_LSB = 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          req = '0;
    logic [1:0]          rd = '0;
    logic [1:0]          wr = '0;
    logic [2*ADDR_W-1:0] addr = '0;
    logic [2*DATA_W-1:0] wdata = '0;
    logic [3:0]          mem_busy = '0;
    logic [DATA_W-1:0]   mem_rdata = '0;
    logic                mem_err = 1'b0;
    logic [1:0]          gnt, stall, rvalid, err;
    logic [DATA_W-1:0]   rdata, mem_wdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd, mem_wr;

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BANK_LSB(BANK_LSB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .gnt(gnt), .stall(stall), .rvalid(rvalid),
        .rdata(rdata), .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_busy(mem_busy),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the memory, whether we are draining, who
    // released last, and the reads still in flight (oldest first).
    typedef struct { int due; int id; } rd_t;
    rd_t q[$];
    int  m_owner = -1;
    bit  m_drain = 0;
    int  m_last  = 1;
    int  cyc     = 0;
    bit  m_iss_rd;
    int  m_iss_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, obs, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_owner = -1;
        m_drain = 0;
        m_last  = 1;
    endtask

    // Expected outputs for the current cycle, compared against the DUT
    task automatic check_outputs();
        logic [1:0]  e_gnt   = 2'b00;
        logic [1:0]  e_stall = 2'b11;
        logic [1:0]  e_rv    = 2'b00;
        logic [1:0]  e_err   = 2'b00;
        logic        e_rd    = 1'b0;
        logic        e_wr    = 1'b0;
        logic [15:0] a, d;
        int          o, bank;
        m_iss_rd = 0;
        m_iss_id = 0;
        if (m_owner >= 0) begin
            o = m_owner;
            e_gnt[o] = 1'b1;
            if (req[o]) begin
                a = (o == 1) ? addr[31:16] : addr[15:0];
                d = (o == 1) ? wdata[31:16] : wdata[15:0];
                bank = (int'(a) >> BANK_LSB) % 4;
                if (rd[o] && wr[o]) begin
                    e_stall[o] = 1'b0;
                    e_err[o]   = 1'b1;
                end else if (rd[o] || wr[o]) begin
                    if (!mem_busy[bank]) begin
                        e_stall[o] = 1'b0;
                        e_rd = rd[o];
                        e_wr = wr[o];
                        chk("mem_addr", mem_addr, a);
                        if (e_wr) chk("mem_wdata", mem_wdata, d);
                        m_iss_rd = e_rd;
                        m_iss_id = o;
                    end
                end else begin
                    e_stall[o] = 1'b0;
                end
            end
        end
        foreach (q[k]) if (q[k].due == cyc) e_rv[q[k].id] = 1'b1;
        if (mem_err) begin
            if (q.size() > 0)     e_err[q[0].id] = 1'b1;
            else if (m_owner >= 0) e_err[m_owner] = 1'b1;
        end
        chk("gnt", gnt, e_gnt);
        chk("stall", stall, e_stall);
        chk("rvalid", rvalid, e_rv);
        chk("err", err, e_err);
        chk("mem_rd", mem_rd, e_rd);
        chk("mem_wr", mem_wr, e_wr);
        if (e_rv != 0) chk("rdata", rdata, mem_rdata);
    endtask

    // Advance the model across a clock edge using this cycle's inputs
    task automatic model_update();
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_drain = 1;
            end
        end else if (m_drain) begin
            if (q.size() == 0) m_drain = 0;
        end else if (req != 2'b00) begin
            if (req == 2'b11) begin
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
                m_owner = 1;
`else
                m_owner = (m_last == 1) ? 0 : 1;
`endif
            end else begin
                m_owner = req[0] ? 0 : 1;
            end
        end
        if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
        if (m_iss_rd) q.push_back('{due: cyc + RD_LAT, id: m_iss_id});
        cyc++;
    endtask

    task automatic run_cycle(input logic [1:0] rq, input logic [1:0] r, input logic [1:0] w,
                             input logic [15:0] a0, input logic [15:0] a1,
                             input logic [3:0] busy, input logic merr);
        @(negedge clk);
        req = rq; rd = r; wr = w; addr = {a1, a0};
        wdata = $urandom; mem_busy = busy; mem_rdata = 16'($urandom); mem_err = merr;
        #1 check_outputs();
        @(posedge clk);
        model_update();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"}, gnt, 2'b00);
        chk({tag, "_stall"}, stall, 2'b11);
        chk({tag, "_rvalid"}, rvalid, 2'b00);
        chk({tag, "_err"}, err, 2'b00);
        chk({tag, "_memrd"}, mem_rd, 1'b0);
        chk({tag, "_memwr"}, mem_wr, 1'b0);
    endtask

    // Asynchronous reset between clock edges, checked before any edge
    task automatic async_reset();
        @(negedge clk);
        req = '0; rd = '0; wr = '0; mem_err = 1'b0; mem_busy = '0;
        #2 rst = 1'b1;
        #1 check_reset_outputs("arst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    logic [1:0] want;
    logic [1:0] r_rnd, w_rnd;

    initial begin
        // Power-on reset
        #3 check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Requester 0 alone: four pipelined reads to banks 0..3
        run_cycle(2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 4'h0, 1'b0);
        run_cycle(2'b01, 2'b01, 2'b00, 16'h0000, 16'h0000, 4'h0, 1'b0);
        run_cycle(2'b01, 2'b01, 2'b00, 16'h0002, 16'h0000, 4'h0, 1'b0);
        run_cycle(2'b01, 2'b01, 2'b00, 16'h0004, 16'h0000, 4'h0, 1'b0);
        run_cycle(2'b01, 2'b01, 2'b00, 16'h0006, 16'h0000, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Tie handling from a fresh reset, release and re-request
        async_reset();
        for (int i = 0; i < 3; i++) run_cycle(2'b11, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b11, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Owner 1 write to a busy bank, then released
        async_reset();
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0002, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b00, 2'b10, 16'h0, 16'h0002, 4'b0010, 1'b0);
        run_cycle(2'b10, 2'b00, 2'b10, 16'h0, 16'h0002, 4'b0010, 1'b0);
        run_cycle(2'b10, 2'b00, 2'b10, 16'h0, 16'h0002, 4'b0000, 1'b0);
        // rd=wr conflict, then a read whose return carries mem_err
        run_cycle(2'b10, 2'b10, 2'b10, 16'h0, 16'h0004, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b10, 2'b00, 16'h0, 16'h0004, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0004, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0004, 4'h0, 1'b1);
        run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0004, 4'h0, 1'b1);
        run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Owner 0 reads then drops req while requester 1 waits
        run_cycle(2'b01, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);
        run_cycle(2'b11, 2'b01, 2'b00, 16'h0010, 16'h0, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b01, 2'b00, 16'h0012, 16'h0, 4'h0, 1'b0);
        for (int i = 0; i < 6; i++) run_cycle(2'b10, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Two reads in flight when reset hits
        run_cycle(2'b10, 2'b10, 2'b00, 16'h0, 16'h0000, 4'h0, 1'b0);
        run_cycle(2'b10, 2'b10, 2'b00, 16'h0, 16'h0002, 4'h0, 1'b0);
        async_reset();
        for (int i = 0; i < 4; i++) run_cycle(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 4'h0, 1'b0);

        // Randomized traffic with long-held requests
        want = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 2; b++) if ($urandom_range(0, 15) == 0) want[b] = ~want[b];
            for (int b = 0; b < 2; b++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: begin r_rnd[b] = 1'b1; w_rnd[b] = 1'b0; end
                    4, 5, 6:    begin r_rnd[b] = 1'b0; w_rnd[b] = 1'b1; end
                    7:          begin r_rnd[b] = 1'b1; w_rnd[b] = 1'b1; end
                    default:    begin r_rnd[b] = 1'b0; w_rnd[b] = 1'b0; end
                endcase
            end
            run_cycle(want, r_rnd, w_rnd, 16'($urandom), 16'($urandom),
                      4'($urandom & $urandom), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
